// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
// Holds operation encodings, FSM state type and iteration count.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mdu_step_core.sv
// mdu_step_core: one radix-2 iteration of the sequencer datapath.
// Multiply: shift-add on {acc_hi, acc_lo} with the multiplier in acc_lo.
// Divide: restoring shift-subtract, remainder in acc_hi, quotient shifts into acc_lo.
module mdu_step_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  // Single iteration: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide.
  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rem  = {acc_hi, acc_lo[WIDTH-1]};
    diff = rem - {1'b0, operand};
    if (is_div) begin
      if (rem >= {1'b0, operand}) begin
        next_hi = diff[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = rem[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: 32-iteration sequential multiply/divide unit with HI/LO registers.
// Optional macro MDU_DIV_ZERO_TRAP_EN adds dz_err and suppresses the HI/LO write on divide by zero.
// busy/done are registered from the current state, so they trail the FSM by one edge.
module mult_div_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
`ifdef MDU_DIV_ZERO_TRAP_EN
  output logic             dz_err,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] LAST_ITER = 6'(ITER_COUNT - 1);

  state_t             state;
  logic [5:0]         cnt;
  logic               is_div_q;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   divisor;

  logic               signed_in;
  logic               is_div_in;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes and sign-corrected results.
  always_comb begin
    signed_in = (op == OP_MULT) || (op == OP_DIV);
    is_div_in = (op == OP_DIV) || (op == OP_DIVU);
    rs_mag    = (signed_in && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    rt_mag    = (signed_in && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    prod_fix  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix   = neg_res ? -acc_lo : acc_lo;
    rem_fix   = neg_rem ? -acc_hi : acc_hi;
  end

  mdu_step_core #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div (is_div_q),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .operand(divisor),
    .next_hi(step_hi),
    .next_lo(step_lo)
  );

  // Sequencer FSM, iteration counter and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef MDU_DIV_ZERO_TRAP_EN
      dz_err   <= 1'b0;
`endif
      hi       <= '0;
      lo       <= '0;
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      divisor  <= '0;
    end else begin
      busy <= (state != ST_IDLE);
      done <= (state == ST_DONE);
`ifdef MDU_DIV_ZERO_TRAP_EN
      dz_err <= (state == ST_DONE) && div_zero;
`endif
      case (state)
        ST_IDLE: begin
          if (start && !busy) begin
            is_div_q <= is_div_in;
            neg_res  <= signed_in && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_rem  <= (op == OP_DIV) && rs_val[WIDTH-1];
            div_zero <= is_div_in && (rt_val == '0);
            acc_hi   <= '0;
            acc_lo   <= rs_mag;
            divisor  <= rt_mag;
            cnt      <= '0;
            state    <= ST_RUN;
          end else if (!busy) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        ST_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt == LAST_ITER) begin
            cnt   <= '0;
            state <= ST_FIX;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_FIX: begin
          // With a zero divisor the restoring loop leaves |rs| in acc_hi and all ones
          // in acc_lo, so rem_fix reproduces rs_val exactly.
          if (div_zero) begin
`ifndef MDU_DIV_ZERO_TRAP_EN
            hi <= rem_fix;
            lo <= '1;
`endif
          end else if (is_div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: directed self-checking bench for mult_div_sequencer.
// Honours MDU_DIV_ZERO_TRAP_EN for the dz_err port and divide-by-zero expectations.
module tb_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MDU_DIV_ZERO_TRAP_EN
  logic        dz_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_sequencer #(
    .WIDTH(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
`ifdef MDU_DIV_ZERO_TRAP_EN
    .dz_err(dz_err),
`endif
    .hi    (hi),
    .lo    (lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after the start edge and checks latency, result and return to idle.
  task automatic wait_result(input string name, input logic [1:0] o, input logic [31:0] b,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 34) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (seen=%0b) expected 34", name, n, seen);
    end
    checks++;
    if (hi !== exp_hi) begin
      errors++;
      $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi);
    end
    checks++;
    if (lo !== exp_lo) begin
      errors++;
      $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo);
    end
`ifdef MDU_DIV_ZERO_TRAP_EN
    checks++;
    if (dz_err !== (o[1] && b == 32'h0)) begin
      errors++;
      $display("FAIL %s dz_err: got %b expected %b", name, dz_err, (o[1] && b == 32'h0));
    end
`else
    if (o[1] && b == 32'h0) $display("note %s: divide by zero without trap", name);
`endif
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after_done: got busy=%b done=%b expected 0/0", name, busy, done);
    end
  endtask

  // Launches an operation, scrambles the operand inputs after the start edge, then waits.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    op     = o;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    op     = ~o;
    rs_val = 32'h1357_9BDF;
    rt_val = 32'h2468_ACE0;
    wait_result(name, o, b, exp_hi, exp_lo);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    rs_val = '0;
    rt_val = '0;
    mthi = 1'b0;
    mtlo = 1'b0;
    wdata = '0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multiply();
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_neg7xneg6", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_002A);
    run_op("multu_shift", 2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
  endtask

  task automatic test_divide();
    run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100by7", 2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
    run_op("div_7byneg2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
  endtask

  task automatic test_div_overflow();
    run_op("div_min_by_neg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
  endtask

  task automatic test_div_zero();
`ifdef MDU_DIV_ZERO_TRAP_EN
    run_op("divu_by_zero", 2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000);
`else
    run_op("divu_by_zero", 2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
`endif
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'hDEAD_BEEF;
    tick();
    mthi = 1'b0;
    mtlo = 1'b0;
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected deadbeef/deadbeef", hi, lo);
    end
    @(negedge clk);
    mtlo  = 1'b1;
    wdata = 32'hA5A5_A5A5;
    tick();
    mtlo = 1'b0;
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL mtlo_idle: got hi=%h lo=%h expected deadbeef/a5a5a5a5", hi, lo);
    end
  endtask

  task automatic test_mtlo_with_start();
    @(negedge clk);
    mtlo   = 1'b1;
    wdata  = 32'h0000_0000;
    op     = 2'b01;
    rs_val = 32'h0000_0002;
    rt_val = 32'h0000_0003;
    start  = 1'b1;
    tick();
    mtlo  = 1'b0;
    start = 1'b0;
    checks++;
    if (lo !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL mtlo_start_dropped: got lo=%h expected a5a5a5a5", lo);
    end
    wait_result("mtlo_start_op", 2'b01, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006);
  endtask

  task automatic test_reset_abort();
    int done_seen;
    int hilo_bad;
    @(negedge clk);
    op     = 2'b00;
    rs_val = 32'h0000_0007;
    rt_val = 32'h0000_0009;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    start  = 1'b1;
    mthi   = 1'b1;
    wdata  = 32'h0000_1234;
    op     = 2'b11;
    rs_val = 32'h0000_0001;
    rt_val = 32'h0000_0001;
    tick();
    start = 1'b0;
    mthi  = 1'b0;
    checks++;
    if (hi !== 32'h0000_0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignores_pulses: got hi=%h busy=%b expected 00000000/1", hi, busy);
    end
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort_state: got busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    hilo_bad  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      if (hi !== 32'h0 || lo !== 32'h0) hilo_bad++;
    end
    checks++;
    if (done_seen != 0 || hilo_bad != 0) begin
      errors++;
      $display("FAIL reset_abort_quiet: got %0d active cycles, %0d hilo changes expected 0/0", done_seen, hilo_bad);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_overflow();
    test_div_zero();
    test_mthi_mtlo();
    test_mtlo_with_start();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
